// File: rtl/kernel_ram_responder_if.sv
// Kernel/debug bus for kernel_ram_responder.
// master = kernel + debug side, slave = the responder.
interface kernel_ram_responder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] raddr0;
    logic [DATA_W-1:0] rdata0;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wen;
    logic [ADDR_W-1:0] debug_write_addr;
    logic [DATA_W-1:0] debug_write_data;
    logic              debug_write_en;
    logic [ADDR_W-1:0] debug_addr;
    logic [DATA_W-1:0] debug_data;
    logic              wr_collision;
    logic [15:0]       kernel_wr_count;

    modport master (
        output raddr0, raddr1, waddr, wdata, wen,
        output debug_write_addr, debug_write_data,
        output debug_write_en, debug_addr,
        input  rdata0, rdata1, debug_data,
        input  wr_collision, kernel_wr_count
    );

    modport slave (
        input  raddr0, raddr1, waddr, wdata, wen,
        input  debug_write_addr, debug_write_data,
        input  debug_write_en, debug_addr,
        output rdata0, rdata1, debug_data,
        output wr_collision, kernel_wr_count
    );
endinterface

// File: rtl/kernel_ram_responder.sv
// Synthesizable RAM responder for HLS kernels: two read ports, one kernel
// write port, debug preload/inspect ports, collision flag and write counter.
module kernel_ram_responder #(
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input logic clk,
    input logic rst,
    kernel_ram_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic        dbg_we;
    logic        krn_req;
    logic        krn_we;
    logic        coll_d, coll_q;
    logic [15:0] cnt_d, cnt_q;

    // Debug writes ignore rst so inputs can be preloaded under reset.
    always_comb begin
        dbg_we  = bus.debug_write_en && in_range(bus.debug_write_addr);
        krn_req = bus.wen && rst && in_range(bus.waddr);
        coll_d  = krn_req && dbg_we &&
                  (bus.debug_write_addr == bus.waddr);
        krn_we  = krn_req && !coll_d;
        cnt_d   = cnt_q;
        if (krn_we && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Memory has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (dbg_we) begin
            mem_q[idx(bus.debug_write_addr)] <= bus.debug_write_data;
        end
        if (krn_we) begin
            mem_q[idx(bus.waddr)] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            coll_q <= coll_d;
            cnt_q  <= cnt_d;
        end
    end

    logic [ADDR_W-1:0] ra       [2];
    logic [DATA_W-1:0] rd_comb  [2];
    logic [DATA_W-1:0] rdata_d  [2];

    assign ra[0] = bus.raddr0;
    assign ra[1] = bus.raddr1;

    // Forwarding order mirrors write priority: debug data last wins.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_comb[p] = '0;
            rdata_d[p] = '0;
            if (in_range(ra[p])) begin
                rd_comb[p] = mem_q[idx(ra[p])];
                rdata_d[p] = rd_comb[p];
                if (krn_we && (bus.waddr == ra[p])) begin
                    rdata_d[p] = bus.wdata;
                end
                if (dbg_we && (bus.debug_write_addr == ra[p])) begin
                    rdata_d[p] = bus.debug_write_data;
                end
            end
        end
    end

    generate
        if (READ_LAT == 0) begin : g_comb_rd
            assign bus.rdata0 = rd_comb[0];
            assign bus.rdata1 = rd_comb[1];
        end else begin : g_reg_rd
            logic [DATA_W-1:0] rdata_q [2];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdata_q[0] <= '0;
                    rdata_q[1] <= '0;
                end else begin
                    rdata_q[0] <= rdata_d[0];
                    rdata_q[1] <= rdata_d[1];
                end
            end

            assign bus.rdata0 = rdata_q[0];
            assign bus.rdata1 = rdata_q[1];
        end
    endgenerate

    assign bus.debug_data      = in_range(bus.debug_addr) ?
                                 mem_q[idx(bus.debug_addr)] : '0;
    assign bus.wr_collision    = coll_q;
    assign bus.kernel_wr_count = cnt_q;

endmodule

// File: tb/tb_kernel_ram_responder.sv
// Randomized bench for kernel_ram_responder: a registered-read and a
// combinational-read instance share stimulus and one memory model.
module tb_kernel_ram_responder;
    localparam int D  = 20;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk;
    logic rst;

    logic [AW-1:0] raddr0, raddr1, waddr, dwa, daddr;
    logic [DW-1:0] wdata, dwd;
    logic          wen, dwe;

    kernel_ram_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
    kernel_ram_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();

    assign if1.raddr0 = raddr0;
    assign if1.raddr1 = raddr1;
    assign if1.waddr  = waddr;
    assign if1.wdata  = wdata;
    assign if1.wen    = wen;
    assign if1.debug_write_addr = dwa;
    assign if1.debug_write_data = dwd;
    assign if1.debug_write_en   = dwe;
    assign if1.debug_addr       = daddr;

    assign if0.raddr0 = raddr0;
    assign if0.raddr1 = raddr1;
    assign if0.waddr  = waddr;
    assign if0.wdata  = wdata;
    assign if0.wen    = wen;
    assign if0.debug_write_addr = dwa;
    assign if0.debug_write_data = dwd;
    assign if0.debug_write_en   = dwe;
    assign if0.debug_addr       = daddr;

    kernel_ram_responder #(
        .DEPTH(D), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    kernel_ram_responder #(
        .DEPTH(D), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m [D];
    int            cnt;
    logic          e_coll;
    logic [DW-1:0] e_r0, e_r1;

    task automatic chk(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdm(input logic [AW-1:0] a);
        return (int'(a) < D) ? m[a] : '0;
    endfunction

    // One clock: apply the write rules to the model, then compare.
    task automatic step();
        bit dok, kreq, cl, kok;
        @(posedge clk);
        dok  = dwe && (int'(dwa) < D);
        kreq = wen && rst && (int'(waddr) < D);
        cl   = kreq && dok && (dwa == waddr);
        kok  = kreq && !cl;
        if (kok) begin
            m[waddr] = wdata;
            if (cnt < 65535) cnt++;
        end
        if (dok) m[dwa] = dwd;
        if (!rst) cnt = 0;
        e_coll = cl;
        e_r0   = rst ? rdm(raddr0) : '0;
        e_r1   = rst ? rdm(raddr1) : '0;
        #1;
        chk("rd0_lat1", if1.rdata0, e_r0);
        chk("rd1_lat1", if1.rdata1, e_r1);
        chk("rd0_lat0", if0.rdata0, rdm(raddr0));
        chk("rd1_lat0", if0.rdata1, rdm(raddr1));
        chk("dbg_data", if1.debug_data, rdm(daddr));
        chk("coll", {31'd0, if1.wr_collision}, {31'd0, e_coll});
        chk("count", {16'd0, if1.kernel_wr_count}, 32'(cnt));
        chk("count0", {16'd0, if0.kernel_wr_count}, 32'(cnt));
    endtask

    logic [DW-1:0] pre0;
    int            cnt_prev;

    initial begin
        rst = 1'b0;
        raddr0 = 5'd10; raddr1 = 5'd11;
        waddr = '0; wdata = '0; wen = 1'b0;
        dwa = '0; dwd = '0; dwe = 1'b0; daddr = 5'd11;
        cnt = 0;
        e_coll = 1'b0;

        // Preload under reset
        dwe = 1'b1; dwa = 5'd10; dwd = 32'd10;
        step();
        dwa = 5'd11; dwd = 32'd5;
        step();
        chk("t1_dbg", if1.debug_data, 32'd5);
        chk("t1_cnt", {16'd0, if1.kernel_wr_count}, 32'd0);
        chk("t1_rd_rst", if1.rdata0, 32'd0);
        for (int a = 0; a < D; a++) begin
            if (a != 10 && a != 11) begin
                dwa = AW'(a); dwd = $urandom;
                step();
            end
        end
        dwe = 1'b0;

        // Kernel write blocked in reset
        daddr = 5'd0;
        pre0 = m[0];
        wen = 1'b1; waddr = 5'd0; wdata = 32'd3;
        if (pre0 == 32'd3) begin
            wdata = 32'd4;
        end
        step();
        chk("t5_guard", if1.debug_data, pre0);
        chk("t5_cnt0", {16'd0, if1.kernel_wr_count}, 32'd0);
        wen = 1'b0; rst = 1'b1;
        step();
        wen = 1'b1; wdata = 32'd3;
        step();
        chk("t5_mem", if1.debug_data, 32'd3);
        chk("t5_cnt1", {16'd0, if1.kernel_wr_count}, 32'd1);

        // Read latency
        wen = 1'b0; raddr0 = 5'd10;
        step();
        dwe = 1'b1; dwa = 5'd3; dwd = 32'd7;
        step();
        dwe = 1'b0; raddr0 = 5'd3;
        #1;
        chk("t2_lat0_now", if0.rdata0, 32'd7);
        chk("t2_lat1_old", if1.rdata0, 32'd10);
        step();
        chk("t2_lat1_new", if1.rdata0, 32'd7);

        // Write-first forwarding
        wen = 1'b1; waddr = 5'd4; wdata = 32'd9; raddr1 = 5'd4;
        step();
        chk("t3_fwd", if1.rdata1, 32'd9);

        // Collision
        cnt_prev = cnt;
        waddr = 5'd2; wdata = 32'd1;
        dwe = 1'b1; dwa = 5'd2; dwd = 32'd2; daddr = 5'd2;
        step();
        chk("t4_coll", {31'd0, if1.wr_collision}, 32'd1);
        chk("t4_mem", if1.debug_data, 32'd2);
        chk("t4_cnt", {16'd0, if1.kernel_wr_count}, 32'(cnt_prev));
        wen = 1'b0; dwe = 1'b0;
        step();
        chk("t4_pulse", {31'd0, if1.wr_collision}, 32'd0);

        // Out of range
        cnt_prev = cnt;
        wen = 1'b1; waddr = 5'd25; wdata = 32'hDEAD; raddr0 = 5'd25;
        step();
        chk("t6_rd", if1.rdata0, 32'd0);
        chk("t6_rd0", if0.rdata0, 32'd0);
        chk("t6_cnt", {16'd0, if1.kernel_wr_count}, 32'(cnt_prev));

        // Random traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 19) != 0);
            wen    = $urandom_range(0, 1) == 1;
            waddr  = AW'($urandom_range(0, 23));
            wdata  = $urandom;
            dwe    = $urandom_range(0, 2) == 0;
            dwa    = ($urandom_range(0, 3) == 0) ? waddr :
                     AW'($urandom_range(0, 23));
            dwd    = $urandom;
            raddr0 = ($urandom_range(0, 3) == 0) ? waddr :
                     AW'($urandom_range(0, 23));
            raddr1 = ($urandom_range(0, 3) == 0) ? dwa :
                     AW'($urandom_range(0, 23));
            daddr  = AW'($urandom_range(0, 23));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
